// File: rtl/router_sync_ctrl.sv
// Router synchroniser: latches the destination port, steers FIFO write enables and full flags,
// and flushes any output FIFO whose data has sat unread for TIMEOUT consecutive cycles.
module router_sync_ctrl #(
   parameter int TIMEOUT = 30,
   parameter int CW      = 5
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       detect_add,
   input  logic [1:0] data_in,
   input  logic       write_enb_reg,
   input  logic       read_enb_0,
   input  logic       read_enb_1,
   input  logic       read_enb_2,
   input  logic       empty_0,
   input  logic       empty_1,
   input  logic       empty_2,
   input  logic       full_0,
   input  logic       full_1,
   input  logic       full_2,
   output logic [2:0] write_enb,
   output logic       fifo_full,
   output logic       vld_out_0,
   output logic       vld_out_1,
   output logic       vld_out_2,
   output logic       soft_reset_0,
   output logic       soft_reset_1,
   output logic       soft_reset_2
);

   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [1:0]         addr_q;
   logic [2:0]         read_enb;
   logic [2:0]         empty;
   logic [2:0]         stall;
   logic [2:0]         soft_reset;
   logic [2:0][CW-1:0] cnt;

   assign read_enb = {read_enb_2, read_enb_1, read_enb_0};
   assign empty    = {empty_2, empty_1, empty_0};

   assign vld_out_0 = ~empty_0;
   assign vld_out_1 = ~empty_1;
   assign vld_out_2 = ~empty_2;

   // A port stalls when it has data that nobody is reading.
   assign stall = ~empty & ~read_enb;

   assign soft_reset_0 = soft_reset[0];
   assign soft_reset_1 = soft_reset[1];
   assign soft_reset_2 = soft_reset[2];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q <= 2'b00;
      end else if (detect_add) begin
         addr_q <= data_in;
      end
   end

   // Decode uses the registered address, so a capture only affects the following cycle.
   always_comb begin
      write_enb = 3'b000;
      fifo_full = 1'b0;
      case (addr_q)
         2'b00: begin
            write_enb = {2'b00, write_enb_reg};
            fifo_full = full_0;
         end
         2'b01: begin
            write_enb = {1'b0, write_enb_reg, 1'b0};
            fifo_full = full_1;
         end
         2'b10: begin
            write_enb = {write_enb_reg, 2'b00};
            fifo_full = full_2;
         end
         default: begin
            write_enb = 3'b000;
            fifo_full = 1'b0;
         end
      endcase
   end

   // Per-port stall counters; the flush pulse fires on the TIMEOUT-th stalled edge and the window restarts.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt        <= '0;
         soft_reset <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!stall[i]) begin
               cnt[i]        <= '0;
               soft_reset[i] <= 1'b0;
            end else if (cnt[i] == LAST) begin
               cnt[i]        <= '0;
               soft_reset[i] <= 1'b1;
            end else begin
               cnt[i]        <= cnt[i] + CW'(1);
               soft_reset[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Scoreboard bench for router_sync_ctrl: expected output vectors {write_enb, fifo_full, vld, soft_reset}
// are queued as stimulus is applied and checked once the DUT has responded.
module tb_router_sync_ctrl;

   localparam int TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       resetn;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic       empty_0, empty_1, empty_2;
   logic       full_0, full_1, full_2;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;

   int         compared   = 0;
   int         mismatched = 0;
   logic [9:0] sb_q[$];
   logic [9:0] exp_v;
   logic [9:0] obs;

   always #5 clk = ~clk;

   assign obs = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
                 soft_reset_2, soft_reset_1, soft_reset_0};

   router_sync_ctrl #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .detect_add   (detect_add),
      .data_in      (data_in),
      .write_enb_reg(write_enb_reg),
      .read_enb_0   (read_enb_0),
      .read_enb_1   (read_enb_1),
      .read_enb_2   (read_enb_2),
      .empty_0      (empty_0),
      .empty_1      (empty_1),
      .empty_2      (empty_2),
      .full_0       (full_0),
      .full_1       (full_1),
      .full_2       (full_2),
      .write_enb    (write_enb),
      .fifo_full    (fifo_full),
      .vld_out_0    (vld_out_0),
      .vld_out_1    (vld_out_1),
      .vld_out_2    (vld_out_2),
      .soft_reset_0 (soft_reset_0),
      .soft_reset_1 (soft_reset_1),
      .soft_reset_2 (soft_reset_2)
   );

   function automatic logic [9:0] pack(input logic [2:0] we, input logic ff,
                                       input logic [2:0] vld, input logic [2:0] sr);
      return {we, ff, vld, sr};
   endfunction

   // Advance one rising edge and settle 1 ns past it, away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_empty(input logic [2:0] e);
      {empty_2, empty_1, empty_0} = e;
   endtask

   task automatic set_full(input logic [2:0] f);
      {full_2, full_1, full_0} = f;
   endtask

   task automatic idle_clear();
      set_empty(3'b111);
      {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
      write_enb_reg = 1'b0;
      detect_add    = 1'b0;
      set_full(3'b000);
      tick();
   endtask

   task automatic test_reset();
      resetn        = 1'b0;
      detect_add    = 1'b0;
      data_in       = 2'b00;
      write_enb_reg = 1'b0;
      {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
      set_empty(3'b101);
      set_full(3'b001);
      #2;
      sb_q.push_back(pack(3'b000, 1'b1, 3'b010, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL reset_idle: got %b expected %b", obs, exp_v);
      end
      write_enb_reg = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sb_q.push_back(pack(3'b001, 1'b1, 3'b010, 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL reset_hold_%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      resetn = 1'b1;
      idle_clear();
   endtask

   task automatic test_addr_decode();
      logic [2:0] oh;
      detect_add = 1'b1;
      data_in    = 2'b01;
      tick();
      detect_add    = 1'b0;
      write_enb_reg = 1'b1;
      set_full(3'b010);
      #1;
      sb_q.push_back(pack(3'b010, 1'b1, 3'b000, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL decode_01: got %b expected %b", obs, exp_v);
      end
      for (int a = 0; a < 3; a++) begin
         oh         = 3'b001 << a;
         detect_add = 1'b1;
         data_in    = 2'(a);
         tick();
         detect_add = 1'b0;
         for (int p = 0; p < 2; p++) begin
            set_full(p == 0 ? (3'b111 & ~oh) : oh);
            #1;
            sb_q.push_back(pack(oh, p == 1, 3'b000, 3'b000));
            exp_v = sb_q.pop_front();
            compared++;
            if (obs !== exp_v) begin
               mismatched++;
               $display("[TB] FAIL decode_a%0d_p%0d: got %b expected %b", a, p, obs, exp_v);
            end
         end
      end
      write_enb_reg = 1'b0;
      #1;
      sb_q.push_back(pack(3'b000, 1'b1, 3'b000, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL decode_no_req: got %b expected %b", obs, exp_v);
      end
      idle_clear();
   endtask

   task automatic test_invalid_addr();
      detect_add = 1'b1;
      data_in    = 2'b11;
      tick();
      detect_add    = 1'b0;
      write_enb_reg = 1'b1;
      set_full(3'b111);
      #1;
      sb_q.push_back(pack(3'b000, 1'b0, 3'b000, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL invalid_addr: got %b expected %b", obs, exp_v);
      end
      idle_clear();
   endtask

   task automatic test_back_to_back();
      detect_add = 1'b1;
      data_in    = 2'b01;
      tick();
      data_in       = 2'b10;
      write_enb_reg = 1'b1;
      set_full(3'b100);
      #1;
      sb_q.push_back(pack(3'b010, 1'b0, 3'b000, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL b2b_old_addr: got %b expected %b", obs, exp_v);
      end
      tick();
      detect_add = 1'b0;
      #1;
      sb_q.push_back(pack(3'b100, 1'b1, 3'b000, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL b2b_new_addr: got %b expected %b", obs, exp_v);
      end
      detect_add = 1'b1;
      data_in    = 2'b00;
      tick();
      detect_add = 1'b0;
      #1;
      sb_q.push_back(pack(3'b001, 1'b0, 3'b000, 3'b000));
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL b2b_back_to_00: got %b expected %b", obs, exp_v);
      end
      idle_clear();
   endtask

   task automatic test_timeout();
      set_empty(3'b011);
      for (int k = 1; k <= 2 * TIMEOUT; k++) begin
         sb_q.push_back(pack(3'b000, 1'b0, 3'b100, (k % TIMEOUT == 0) ? 3'b100 : 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL timeout_edge%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      set_empty(3'b111);
      sb_q.push_back(pack(3'b000, 1'b0, 3'b000, 3'b000));
      tick();
      exp_v = sb_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("[TB] FAIL timeout_release: got %b expected %b", obs, exp_v);
      end
      idle_clear();
   endtask

   task automatic test_read_rescue();
      set_empty(3'b110);
      for (int k = 1; k <= TIMEOUT; k++) begin
         read_enb_0 = (k == TIMEOUT);
         sb_q.push_back(pack(3'b000, 1'b0, 3'b001, 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL rescue_pre%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      read_enb_0 = 1'b0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         sb_q.push_back(pack(3'b000, 1'b0, 3'b001, (k == TIMEOUT) ? 3'b001 : 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL rescue_post%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      idle_clear();
   endtask

   task automatic test_concurrency();
      set_empty(3'b100);
      for (int k = 1; k <= TIMEOUT + 1; k++) begin
         sb_q.push_back(pack(3'b000, 1'b0, 3'b011, (k == TIMEOUT) ? 3'b011 : 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL concur_edge%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      idle_clear();
   endtask

   task automatic test_reset_mid_count();
      set_empty(3'b011);
      for (int k = 1; k <= 20; k++) begin
         sb_q.push_back(pack(3'b000, 1'b0, 3'b100, 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL midrst_pre%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      #2;
      resetn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sb_q.push_back(pack(3'b000, 1'b0, 3'b100, 3'b000));
         if (k == 0) #1;
         else tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL midrst_in_reset%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      resetn = 1'b1;
      for (int k = 1; k <= TIMEOUT; k++) begin
         sb_q.push_back(pack(3'b000, 1'b0, 3'b100, (k == TIMEOUT) ? 3'b100 : 3'b000));
         tick();
         exp_v = sb_q.pop_front();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL midrst_post%0d: got %b expected %b", k, obs, exp_v);
         end
      end
      idle_clear();
   endtask

   initial begin
      test_reset();
      test_addr_decode();
      test_invalid_addr();
      test_back_to_back();
      test_timeout();
      test_read_rescue();
      test_concurrency();
      test_reset_mid_count();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/router_sync_ctrl.md
ROUTER_SYNC_CTRL -- requirements
Module: router_sync_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT, default 30, SHALL set the number of consecutive unread-valid cycles before a port soft reset.
REQ-003 Parameter CW, default 5, SHALL set the timeout counter width; CW SHALL satisfy 2^CW > TIMEOUT-1.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 detect_add  input  1  FSM strobe; capture destination address this cycle.
REQ-007 data_in  input  2  destination address: 00, 01 or 10 selects port 0, 1 or 2; 11 is invalid.
REQ-008 write_enb_reg  input  1  FSM write request for the selected FIFO.
REQ-009 read_enb_0, read_enb_1, read_enb_2  input  1 each  downstream read strobes.
REQ-010 empty_0, empty_1, empty_2  input  1 each  FIFO empty flags.
REQ-011 full_0, full_1, full_2  input  1 each  FIFO full flags.
REQ-012 write_enb  output  3  one-hot FIFO write enables; bit n drives FIFO n.
REQ-013 fifo_full  output  1  full flag of the selected FIFO, returned to the FSM.
REQ-014 vld_out_0, vld_out_1, vld_out_2  output  1 each  port has data.
REQ-015 soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  registered one-cycle FIFO flush pulses.

Function
REQ-016 addr_q (2 bits) SHALL load data_in on a rising edge where detect_add=1 and SHALL hold its value otherwise.
REQ-017 write_enb SHALL be combinational: one-hot of addr_q when write_enb_reg=1 and addr_q!=11; 000 otherwise.
REQ-018 fifo_full SHALL be combinational: full_n for addr_q=n; 0 when addr_q=11.
REQ-019 vld_out_n SHALL equal ~empty_n combinationally, with zero latency.
REQ-020 Each port n SHALL have an independent CW-bit counter cnt_n.
REQ-021 Stall condition: vld_out_n=1 and read_enb_n=0.
REQ-022 On an edge where the stall condition holds and cnt_n<TIMEOUT-1, cnt_n SHALL increment and soft_reset_n SHALL be 0.
REQ-023 On an edge where the stall condition holds and cnt_n==TIMEOUT-1, soft_reset_n SHALL become 1 and cnt_n SHALL clear to 0.
REQ-024 On any edge where the stall condition is false, cnt_n SHALL clear to 0 and soft_reset_n SHALL be 0.
REQ-025 soft_reset_n SHALL be high for exactly one cycle per timeout; with a continuous stall it SHALL recur every TIMEOUT cycles.
REQ-026 A single read_enb_n=1 cycle SHALL restart the full TIMEOUT window.
REQ-027 Ports SHALL time out independently; simultaneous pulses on several ports SHALL be allowed.
REQ-028 detect_add concurrent with write_enb_reg SHALL use the old addr_q for that cycle's write_enb and fifo_full; the new address SHALL take effect from the next cycle.
REQ-029 addr_q and the timeout counters SHALL be unaffected by soft_reset_n.

Reset
REQ-030 While resetn=0, the block SHALL asynchronously force addr_q=00, cnt_0..2=0 and soft_reset_0..2=0.
REQ-031 During reset, write_enb SHALL be 000 if write_enb_reg=0, and vld_out_n SHALL still follow ~empty_n.
REQ-032 Reset asserted mid-timeout SHALL abort the count; after release, a full TIMEOUT stall SHALL be required before the next pulse.

Verification
REQ-033 Address decode: detect_add=1 with data_in=01, then write_enb_reg=1 -> write_enb=010; with full_1=1 -> fifo_full=1.
REQ-034 Invalid address: data_in=11 captured, write_enb_reg=1, full_0..2=111 -> write_enb=000 and fifo_full=0.
REQ-035 Timeout: empty_2=0, read_enb_2=0 held for 30 edges -> soft_reset_2=1 exactly after edge 30 for one cycle; held for 60 edges -> a second pulse after edge 60.
REQ-036 Read rescue: stall for 29 edges, read_enb_0=1 for one cycle, then stall -> no soft_reset_0 until 30 further stall edges have elapsed.
REQ-037 Concurrency: ports 0 and 1 stall from the same edge -> soft_reset_0 and soft_reset_1 pulse in the same cycle, while port 2 (empty) stays 0.
REQ-038 Reset mid-count: stall for 20 edges, then pulse resetn low -> no pulse at the original edge 30; the pulse occurs 30 edges after release.
